// File: rtl/block_serializer_if.sv
// Parallel-load / byte-stream handshake bundle for block_serializer.
// master: serializer side; slave: environment side (block source and byte sink).
interface block_serializer_if #(
    parameter int unsigned MAXELEMENTS = 44
);
    logic                     load_valid;
    logic                     load_ready;
    logic [MAXELEMENTS*8-1:0] load_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               out_byte;
    logic                     out_last;

    modport master (
        input  load_valid, load_data, out_ready,
        output load_ready, out_valid, out_byte, out_last
    );

    modport slave (
        output load_valid, load_data, out_ready,
        input  load_ready, out_valid, out_byte, out_last
    );
endinterface

// File: rtl/block_serializer.sv
// Captures a MAXELEMENTS-byte block and streams it LSB-byte first with valid/ready/last.
// Optional BLOCK_SERIALIZER_CHECKSUM_EN appends an XOR-of-all-bytes trailer byte.
module block_serializer #(
    parameter int unsigned MAXELEMENTS = 44,
    parameter int unsigned COUNTBITS   = 7
) (
    input logic                clk,
    input logic                rst,
    block_serializer_if.master bus
);

    localparam int unsigned DataW = MAXELEMENTS * 8;
`ifdef BLOCK_SERIALIZER_CHECKSUM_EN
    localparam int unsigned LastIdx = MAXELEMENTS;
    localparam logic [COUNTBITS-1:0] CsumCount = COUNTBITS'(MAXELEMENTS - 1);
`else
    localparam int unsigned LastIdx = MAXELEMENTS - 1;
`endif
    localparam logic [COUNTBITS-1:0] LastCount = COUNTBITS'(LastIdx);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e               state_q, state_d;
    logic [DataW-1:0]     data_q, data_d;
    logic [COUNTBITS-1:0] count_q, count_d;
`ifdef BLOCK_SERIALIZER_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;
`endif

    logic sending;
    logic last;
    logic ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            count_q <= '0;
`ifdef BLOCK_SERIALIZER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
`ifdef BLOCK_SERIALIZER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
`ifdef BLOCK_SERIALIZER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        sending = (state_q == StSend);
        last    = sending && (count_q == LastCount);
        ready   = !sending || (last && bus.out_ready);

        if (bus.load_valid && ready) begin
            state_d = StSend;
            data_d  = bus.load_data;
            count_d = '0;
`ifdef BLOCK_SERIALIZER_CHECKSUM_EN
            csum_d  = '0;
`endif
        end else if (sending && bus.out_ready) begin
            data_d  = data_q >> 8;
            count_d = count_q + 1'b1;
`ifdef BLOCK_SERIALIZER_CHECKSUM_EN
            csum_d  = csum_q ^ data_q[7:0];
            // Park the finished checksum in the output byte slot so out_byte stays a register.
            if (count_q == CsumCount) begin
                data_d[7:0] = csum_q ^ data_q[7:0];
            end
`endif
            if (last) begin
                state_d = StIdle;
                count_d = '0;
            end
        end
    end

    assign bus.out_valid  = sending;
    assign bus.out_byte   = data_q[7:0];
    assign bus.out_last   = last;
    assign bus.load_ready = ready;

endmodule

// File: tb/tb_block_serializer.sv
// Self-checking bench for block_serializer: queue-based byte-stream model plus directed scenarios.
module tb_block_serializer;

    localparam int unsigned M = 44;
    localparam int unsigned W = M * 8;
`ifdef BLOCK_SERIALIZER_CHECKSUM_EN
    localparam int unsigned NB  = M + 1;
    localparam bit          Cks = 1'b1;
`else
    localparam int unsigned NB  = M;
    localparam bit          Cks = 1'b0;
`endif

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic       last;
        int         cyc;
    } xfer_t;

    logic clk;
    logic rst;

    block_serializer_if #(.MAXELEMENTS(M)) bus ();

    block_serializer #(
        .MAXELEMENTS(M),
        .COUNTBITS  (7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t  mdl_q[$];
    xfer_t log_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    bit    acc_flag = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [7:0] base, input logic [7:0] step);
        logic [W-1:0] d;
        d = '0;
        for (int k = 0; k < M; k++) d[8*k +: 8] = base + 8'(k) * step;
        return d;
    endfunction

    // Model: queue of bytes still owed downstream. Evaluated at negedge for the coming posedge.
    always @(negedge clk) begin
        exp_t       e;
        bit         ready;
        bit         acc;
        logic [7:0] x;
        cyc++;
        if (!rst) begin
            mdl_q.delete();
            acc_flag = 1'b0;
        end
        check("out_valid", bus.out_valid, mdl_q.size() != 0);
        ready = (mdl_q.size() == 0) || (mdl_q.size() == 1 && bus.out_ready);
        check("load_ready", bus.load_ready, ready);
        if (mdl_q.size() != 0) begin
            check("out_byte", bus.out_byte, mdl_q[0].b);
            check("out_last", bus.out_last, mdl_q[0].last);
        end
        if (rst) begin
            if (bus.out_valid && bus.out_ready) log_q.push_back('{bus.out_byte, bus.out_last, cyc});
            acc = bus.load_valid && ready;
            if (bus.out_ready && mdl_q.size() != 0) void'(mdl_q.pop_front());
            if (acc) begin
                x = 8'h00;
                for (int k = 0; k < M; k++) begin
                    e.b    = bus.load_data[8*k +: 8];
                    e.last = !Cks && (k == M - 1);
                    mdl_q.push_back(e);
                    x ^= e.b;
                end
                if (Cks) begin
                    e.b    = x;
                    e.last = 1'b1;
                    mdl_q.push_back(e);
                end
            end
            acc_flag = acc;
        end
    end

    task automatic do_load(input logic [W-1:0] d, input string name);
        bit got;
        got = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            #1;
            got = acc_flag;
        end
        check({name, " load accepted"}, got, 1);
        @(posedge clk);
        #2;
        bus.load_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            #1;
            if (mdl_q.size() == 0) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #2;
                if (toggle) bus.out_ready = ~bus.out_ready;
            end
        end
        check({name, " drained"}, done, 1);
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
    endtask

    task automatic wait_log(input int n, input string name);
        for (int i = 0; i < 100 && log_q.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        check({name, " transfers reached"}, log_q.size() >= n, 1);
    endtask

    initial begin
        logic [W-1:0] blk_a;
        logic [W-1:0] blk_b;
        logic [W-1:0] blk_c;
        int           nl;
        blk_a = mk(8'h00, 8'h01);
        blk_b = mk(8'hA0, 8'h07);
        blk_c = mk(8'h55, 8'h03);

        rst            = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.out_ready  = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_byte", bus.out_byte, 8'h00);
        check("reset out_last", bus.out_last, 0);
        check("reset load_ready", bus.load_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;

        // Streaming with continuous ready.
        log_q.delete();
        do_load(blk_a, "s1");
        drain(1'b0, "s1");
        check("s1 count", log_q.size(), NB);
        check("s1 byte0", log_q[0].b, 8'h00);
        check("s1 byte1", log_q[1].b, 8'h01);
        check("s1 byte43", log_q[43].b, 8'h2B);
        check("s1 gapless", log_q[NB-1].cyc - log_q[0].cyc, NB - 1);
        nl = 0;
        foreach (log_q[i]) nl += int'(log_q[i].last);
        check("s1 last count", nl, 1);
        check("s1 last on final", log_q[NB-1].last, 1);
`ifdef BLOCK_SERIALIZER_CHECKSUM_EN
        // XOR of 0x00..0x2B: every aligned group of four cancels.
        check("s1 checksum byte", log_q[44].b, 8'h00);
        check("s1 byte43 not last", log_q[43].last, 0);
`endif

        // Alternating stall.
        log_q.delete();
        do_load(blk_a, "s2");
        drain(1'b1, "s2");
        check("s2 count", log_q.size(), NB);
        for (int k = 0; k < M; k++) check("s2 byte order", log_q[k].b, 8'(k));

        // Back-to-back blocks, load_valid held through all of A.
        log_q.delete();
        do_load(blk_a, "s3a");
        do_load(blk_b, "s3b");
        drain(1'b0, "s3");
        check("s3 count", log_q.size(), 2 * NB);
`ifdef BLOCK_SERIALIZER_CHECKSUM_EN
        check("s3 A final byte", log_q[NB-1].b, 8'h00);
`else
        check("s3 A final byte", log_q[NB-1].b, 8'h2B);
`endif
        check("s3 A final last", log_q[NB-1].last, 1);
        check("s3 B byte0", log_q[NB].b, 8'hA0);
        check("s3 B byte1", log_q[NB+1].b, 8'hA7);
        check("s3 no bubble", log_q[NB].cyc - log_q[NB-1].cyc, 1);

        // Reset mid-block.
        log_q.delete();
        do_load(blk_a, "s4");
        wait_log(10, "s4");
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("s4 rst out_valid", bus.out_valid, 0);
        check("s4 rst out_byte", bus.out_byte, 8'h00);
        check("s4 rst out_last", bus.out_last, 0);
        check("s4 rst load_ready", bus.load_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("s4 nothing after abort", log_q.size(), 10);
        check("s4 idle out_valid", bus.out_valid, 0);
        do_load(blk_b, "s4b");
        drain(1'b0, "s4b");
        check("s4 count", log_q.size(), 10 + NB);
        check("s4 new byte0", log_q[10].b, 8'hA0);

        // Stray load_valid pulse during transfer 5.
        log_q.delete();
        do_load(blk_a, "s5");
        wait_log(5, "s5");
        @(posedge clk);
        #2;
        bus.load_valid = 1'b1;
        bus.load_data  = blk_c;
        @(posedge clk);
        #2;
        bus.load_valid = 1'b0;
        drain(1'b0, "s5");
        check("s5 count", log_q.size(), NB);
        check("s5 byte5", log_q[5].b, 8'h05);
        check("s5 byte6", log_q[6].b, 8'h06);
        check("s5 byte43", log_q[43].b, 8'h2B);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
